// File: rtl/e203_exu_regfile_mp_pkg.sv
// Shared defaults and configuration limits for the multi-port EXU register file.
// Optional feature macro: E203_REGFILE_WR_BYPASS_EN (same-cycle write-to-read bypass).
package e203_exu_regfile_mp_pkg;

    localparam int unsigned E203_XLEN        = 32;
    localparam int unsigned E203_RFIDX_WIDTH = 5;
    localparam int unsigned E203_RFREG_NUM   = 32;

    localparam int unsigned RF_RD_PORTS_MAX = 4;
    localparam int unsigned RF_WR_PORTS_MAX = 3;

    function automatic bit rf_cfg_ok(input int unsigned rd_ports, input int unsigned wr_ports,
                                     input int unsigned reg_num, input int unsigned idx_w);
        return (rd_ports >= 1) && (rd_ports <= RF_RD_PORTS_MAX) &&
               (wr_ports >= 1) && (wr_ports <= RF_WR_PORTS_MAX) &&
               (reg_num >= 2) && (reg_num <= (32'd1 << idx_w));
    endfunction

endpackage

// File: rtl/e203_exu_rf_wrsel.sv
// Write-port priority select for one register number: reports a hit and the winning payload.
// The highest-numbered enabled port whose index matches wins.
module e203_exu_rf_wrsel #(
    parameter int unsigned DW       = 32,
    parameter int unsigned RFIDX_W  = 5,
    parameter int unsigned WR_PORTS = 2
) (
    input  logic [WR_PORTS-1:0]         wr_en_i,
    input  logic [WR_PORTS*RFIDX_W-1:0] wr_idx_i,
    input  logic [WR_PORTS*DW-1:0]      wr_dat_i,
    input  logic [RFIDX_W-1:0]          reg_i,
    output logic                        hit_o,
    output logic [DW-1:0]               dat_o
);

    always_comb begin
        hit_o = 1'b0;
        dat_o = '0;
        // Ascending scan so a later (higher) port overrides an earlier match.
        for (int k = 0; k < int'(WR_PORTS); k++) begin
            if (wr_en_i[k] && (wr_idx_i[k*RFIDX_W +: RFIDX_W] == reg_i)) begin
                hit_o = 1'b1;
                dat_o = wr_dat_i[k*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// Load-enabled flop bank with asynchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
    parameter int unsigned DW = 32
) (
    input  logic          lden_i,
    input  logic [DW-1:0] dnxt_i,
    output logic [DW-1:0] qout_o,
    input  logic          clk,
    input  logic          rst_n
);

    logic [DW-1:0] qout_d, qout_q;

    always_comb begin
        qout_d = lden_i ? dnxt_i : qout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_q <= '0;
        end else begin
            qout_q <= qout_d;
        end
    end

    assign qout_o = qout_q;

endmodule

// File: rtl/e203_exu_regfile_mp.sv
// Multi-port EXU register file with a per-register long-pipe busy scoreboard.
// Optional feature macro: E203_REGFILE_WR_BYPASS_EN (same-cycle write-to-read bypass).
module e203_exu_regfile_mp
    import e203_exu_regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN      = E203_XLEN,
    parameter int unsigned RFIDX_W   = E203_RFIDX_WIDTH,
    parameter int unsigned RFREG_NUM = E203_RFREG_NUM,
    parameter int unsigned RD_PORTS  = 2,
    parameter int unsigned WR_PORTS  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [RD_PORTS*RFIDX_W-1:0] rd_idx,
    output logic [RD_PORTS*XLEN-1:0]    rd_dat,
    output logic [RD_PORTS-1:0]         rd_busy,
    input  logic [WR_PORTS-1:0]         wr_en,
    input  logic [WR_PORTS*RFIDX_W-1:0] wr_idx,
    input  logic [WR_PORTS*XLEN-1:0]    wr_dat,
    input  logic [WR_PORTS-1:0]         wr_clr,
    input  logic                        iss_vld,
    input  logic [RFIDX_W-1:0]          iss_idx,
    output logic                        iss_rdy,
    output logic [RFREG_NUM-1:0]        busy_vec,
    input  logic                        flush,
    output logic [XLEN-1:0]             x1_r
);

    localparam bit CfgOk = rf_cfg_ok(RD_PORTS, WR_PORTS, RFREG_NUM, RFIDX_W);

    cfg_ok_a: assert property (@(posedge clk) CfgOk);

    // ------------------------------------------------------------------ storage
    logic [XLEN-1:0] rf_q [RFREG_NUM];

    assign rf_q[0] = '0;

    for (genvar i = 1; i < RFREG_NUM; i++) begin : g_reg
        logic            wr_hit;
        logic [XLEN-1:0] rf_d;

        e203_exu_rf_wrsel #(
            .DW       (XLEN),
            .RFIDX_W  (RFIDX_W),
            .WR_PORTS (WR_PORTS)
        ) u_wrsel (
            .wr_en_i  (wr_en),
            .wr_idx_i (wr_idx),
            .wr_dat_i (wr_dat),
            .reg_i    (RFIDX_W'(i)),
            .hit_o    (wr_hit),
            .dat_o    (rf_d)
        );

        sirv_gnrl_dfflr #(
            .DW (XLEN)
        ) u_rf (
            .lden_i (wr_hit),
            .dnxt_i (rf_d),
            .qout_o (rf_q[i]),
            .clk    (clk),
            .rst_n  (rst_n)
        );
    end

    assign x1_r = rf_q[1];

    // --------------------------------------------------------------- scoreboard
    logic [RFREG_NUM-1:0] busy_d, busy_q;
    logic [RFREG_NUM-1:0] iss_dec, clr_vec;

    // Bit 0 of both decodes stays 0, so x0 and out-of-range indices never touch busy.
    always_comb begin
        iss_dec = '0;
        clr_vec = '0;
        for (int i = 1; i < int'(RFREG_NUM); i++) begin
            iss_dec[i] = (iss_idx == RFIDX_W'(i));
            for (int k = 0; k < int'(WR_PORTS); k++) begin
                if (wr_en[k] && wr_clr[k] && (wr_idx[k*RFIDX_W +: RFIDX_W] == RFIDX_W'(i))) begin
                    clr_vec[i] = 1'b1;
                end
            end
        end
    end

    assign iss_rdy = ~|(iss_dec & busy_q);

    always_comb begin
        busy_d = (busy_q & ~clr_vec) | ({RFREG_NUM{iss_vld & iss_rdy}} & iss_dec);
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    sirv_gnrl_dfflr #(
        .DW (RFREG_NUM)
    ) u_busy (
        .lden_i (1'b1),
        .dnxt_i (busy_d),
        .qout_o (busy_q),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    assign busy_vec = busy_q;

    // -------------------------------------------------------------- read ports
`ifdef E203_REGFILE_WR_BYPASS_EN
    logic [WR_PORTS*(XLEN+1)-1:0] wr_cd;

    for (genvar k = 0; k < WR_PORTS; k++) begin : g_cd
        assign wr_cd[k*(XLEN+1) +: XLEN+1] = {wr_clr[k], wr_dat[k*XLEN +: XLEN]};
    end
`endif

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [RFIDX_W-1:0] idx;
        logic [XLEN-1:0]    st_dat;
        logic               st_busy;
        logic               idx_ok;

        assign idx = rd_idx[p*RFIDX_W +: RFIDX_W];

        always_comb begin
            st_dat  = '0;
            st_busy = 1'b0;
            idx_ok  = 1'b0;
            for (int i = 1; i < int'(RFREG_NUM); i++) begin
                if (idx == RFIDX_W'(i)) begin
                    st_dat  = rf_q[i];
                    st_busy = busy_q[i];
                    idx_ok  = 1'b1;
                end
            end
        end

`ifdef E203_REGFILE_WR_BYPASS_EN
        logic          byp_hit;
        logic [XLEN:0] byp_cd;

        // Same priority select as the storage write, carrying wr_clr alongside the data.
        e203_exu_rf_wrsel #(
            .DW       (XLEN + 1),
            .RFIDX_W  (RFIDX_W),
            .WR_PORTS (WR_PORTS)
        ) u_byp (
            .wr_en_i  (wr_en),
            .wr_idx_i (wr_idx),
            .wr_dat_i (wr_cd),
            .reg_i    (idx),
            .hit_o    (byp_hit),
            .dat_o    (byp_cd)
        );

        assign rd_dat[p*XLEN +: XLEN] = (byp_hit && idx_ok) ? byp_cd[XLEN-1:0] : st_dat;
        assign rd_busy[p]             = st_busy & ~(byp_hit & idx_ok & byp_cd[XLEN]);
`else
        assign rd_dat[p*XLEN +: XLEN] = st_dat;
        assign rd_busy[p]             = st_busy & idx_ok;
`endif
    end

endmodule

// File: tb/tb_e203_exu_regfile_mp.sv
// Self-checking bench: directed steps plus randomized traffic against an array-based model.
module tb_e203_exu_regfile_mp;

    localparam int XL = 32;
    localparam int IW = 5;
    localparam int NR = 16;
    localparam int RP = 2;
    localparam int WP = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [RP*IW-1:0]  rd_idx;
    logic [RP*XL-1:0]  rd_dat;
    logic [RP-1:0]     rd_busy;
    logic [WP-1:0]     wr_en;
    logic [WP*IW-1:0]  wr_idx;
    logic [WP*XL-1:0]  wr_dat;
    logic [WP-1:0]     wr_clr;
    logic              iss_vld;
    logic [IW-1:0]     iss_idx;
    logic              iss_rdy;
    logic [NR-1:0]     busy_vec;
    logic              flush;
    logic [XL-1:0]     x1_r;

    e203_exu_regfile_mp #(
        .XLEN      (XL),
        .RFIDX_W   (IW),
        .RFREG_NUM (NR),
        .RD_PORTS  (RP),
        .WR_PORTS  (WP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (rd_idx),
        .rd_dat   (rd_dat),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_dat   (wr_dat),
        .wr_clr   (wr_clr),
        .iss_vld  (iss_vld),
        .iss_idx  (iss_idx),
        .iss_rdy  (iss_rdy),
        .busy_vec (busy_vec),
        .flush    (flush),
        .x1_r     (x1_r)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: architectural registers and busy bits.
    logic [31:0] m_reg [NR];
    logic [NR-1:0] m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rf(input int idx);
        return (idx > 0) && (idx < NR);
    endfunction

    // Port whose write lands on register idx this cycle (-1 if none).
    function automatic int wr_win(input int idx);
        int w = -1;
        for (int k = WP - 1; k >= 0; k--) begin
            if (w < 0 && wr_en[k] && int'(wr_idx[k*IW +: IW]) == idx) w = k;
        end
        return w;
    endfunction

    function automatic logic [31:0] exp_dat(input int idx);
        if (!in_rf(idx)) return 32'h0;
`ifdef E203_REGFILE_WR_BYPASS_EN
        if (wr_win(idx) >= 0) return wr_dat[wr_win(idx)*XL +: XL];
`endif
        return m_reg[idx];
    endfunction

    function automatic logic exp_busy(input int idx);
        if (!in_rf(idx)) return 1'b0;
`ifdef E203_REGFILE_WR_BYPASS_EN
        if (wr_win(idx) >= 0 && wr_clr[wr_win(idx)]) return 1'b0;
`endif
        return m_busy[idx];
    endfunction

    function automatic logic exp_rdy();
        if (!in_rf(int'(iss_idx))) return 1'b1;
        return !m_busy[iss_idx];
    endfunction

    task automatic check_outputs(input string tag);
        for (int p = 0; p < RP; p++) begin
            check($sformatf("%s rd_dat%0d", tag, p), rd_dat[p*XL +: XL],
                  exp_dat(int'(rd_idx[p*IW +: IW])));
            check($sformatf("%s rd_busy%0d", tag, p), 32'(rd_busy[p]),
                  32'(exp_busy(int'(rd_idx[p*IW +: IW]))));
        end
        check({tag, " busy_vec"}, 32'(busy_vec), 32'(m_busy));
        check({tag, " iss_rdy"}, 32'(iss_rdy), 32'(exp_rdy()));
        check({tag, " x1_r"}, x1_r, m_reg[1]);
    endtask

    // Called just after a falling edge with inputs set; returns after the next falling edge.
    task automatic cycle(input string tag);
        logic [31:0]   nreg [NR];
        logic [NR-1:0] nb;
        #1;
        check_outputs(tag);
        nb = m_busy;
        for (int k = 0; k < WP; k++) begin
            if (wr_en[k] && wr_clr[k] && in_rf(int'(wr_idx[k*IW +: IW])))
                nb[wr_idx[k*IW +: IW]] = 1'b0;
        end
        if (iss_vld && exp_rdy() && in_rf(int'(iss_idx))) nb[iss_idx] = 1'b1;
        if (flush) nb = '0;
        nreg = m_reg;
        for (int i = 1; i < NR; i++) begin
            if (wr_win(i) >= 0) nreg[i] = wr_dat[wr_win(i)*XL +: XL];
        end
        @(posedge clk);
        m_reg  = nreg;
        m_busy = nb;
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en   = '0;
        wr_idx  = '0;
        wr_dat  = '0;
        wr_clr  = '0;
        iss_vld = 1'b0;
        iss_idx = '0;
        flush   = 1'b0;
    endtask

    task automatic set_wr(input int k, input int idx, input logic [31:0] dat, input logic clr);
        wr_en[k]             = 1'b1;
        wr_idx[k*IW +: IW]   = IW'(idx);
        wr_dat[k*XL +: XL]   = dat;
        wr_clr[k]            = clr;
    endtask

    task automatic set_rd(input int a, input int b);
        rd_idx = {IW'(b), IW'(a)};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) m_reg[i] = 32'h0;
        m_busy = '0;

        // Reset held with all write ports active.
        idle();
        rst_n  = 1'b0;
        wr_en  = '1;
        wr_idx = {IW'(5), IW'(1)};
        wr_dat = {32'h5555_0000, 32'h0000_0111};
        set_rd(2, 3);
        repeat (3) @(negedge clk);
        #1;
        check("rst rd_dat0", rd_dat[0 +: XL], 32'h0);
        check("rst rd_dat1", rd_dat[XL +: XL], 32'h0);
        check("rst busy_vec", 32'(busy_vec), 32'h0);
        check("rst x1_r", x1_r, 32'h0);
        check("rst iss_rdy", 32'(iss_rdy), 32'h1);
        rst_n = 1'b1;
        idle();
        @(negedge clk);

        // Both ports hit x5: port 1 wins.
        set_wr(0, 5, 32'h1111, 1'b0);
        set_wr(1, 5, 32'h2222, 1'b0);
        cycle("dual");
        idle();
        set_rd(5, 0);
        #1;
        check("dual x5", rd_dat[0 +: XL], 32'h2222);

        set_wr(0, 0, 32'hDEAD, 1'b0);
        cycle("x0wr");
        idle();
        set_rd(0, 5);
        #1;
        check("x0 read", rd_dat[0 +: XL], 32'h0);

        set_wr(1, 20, 32'hBEEF, 1'b0);
        cycle("oor wr");
        idle();
        set_rd(5, 20);
        #1;
        check("oor read", rd_dat[XL +: XL], 32'h0);
        check("oor x5 kept", rd_dat[0 +: XL], 32'h2222);

        // Scoreboard handshake on x7.
        iss_vld = 1'b1;
        iss_idx = 5'd7;
        cycle("iss7");
        #1;
        check("iss7 busy", 32'(busy_vec[7]), 32'h1);
        check("iss7 rdy", 32'(iss_rdy), 32'h0);
        cycle("iss7 again");
        idle();
        set_wr(1, 7, 32'h77, 1'b1);
        cycle("clr7");
        #1;
        check("clr7 busy", 32'(busy_vec[7]), 32'h0);
        iss_vld = 1'b1;
        iss_idx = 5'd7;
        set_wr(0, 7, 32'h78, 1'b1);
        cycle("setwins");
        idle();
        #1;
        check("setwins busy", 32'(busy_vec[7]), 32'h1);
        flush   = 1'b1;
        iss_vld = 1'b1;
        iss_idx = 5'd9;
        cycle("flush");
        idle();
        #1;
        check("flush busy_vec", 32'(busy_vec), 32'h0);

        // Same-cycle write/clear while reading a busy register.
        set_wr(0, 3, 32'h1234, 1'b0);
        cycle("x3 init");
        idle();
        iss_vld = 1'b1;
        iss_idx = 5'd3;
        cycle("iss3");
        idle();
        set_wr(0, 3, 32'hCAFE, 1'b1);
        set_rd(3, 0);
        #1;
`ifdef E203_REGFILE_WR_BYPASS_EN
        check("byp dat", rd_dat[0 +: XL], 32'hCAFE);
        check("byp busy", 32'(rd_busy[0]), 32'h0);
`else
        check("nobyp dat", rd_dat[0 +: XL], 32'h1234);
        check("nobyp busy", 32'(rd_busy[0]), 32'h1);
`endif
        cycle("byp");
        idle();
        #1;
        check("byp next dat", rd_dat[0 +: XL], 32'hCAFE);
        check("byp next busy", 32'(rd_busy[0]), 32'h0);

        // Randomized traffic with out-of-range indices mixed in.
        for (int n = 0; n < 400; n++) begin
            wr_en   = WP'($urandom);
            wr_clr  = WP'($urandom);
            for (int k = 0; k < WP; k++) begin
                wr_idx[k*IW +: IW] = IW'($urandom_range(0, 19));
                wr_dat[k*XL +: XL] = $urandom;
            end
            iss_vld = 1'($urandom);
            iss_idx = IW'($urandom_range(0, 19));
            flush   = ($urandom_range(0, 15) == 0);
            set_rd($urandom_range(0, 19), $urandom_range(0, 19));
            cycle("rand");
        end

        // Asynchronous reset between clock edges.
        idle();
        set_wr(0, 1, 32'h80, 1'b0);
        iss_vld = 1'b1;
        iss_idx = 5'd4;
        cycle("x1 wr");
        idle();
        set_rd(1, 4);
        #1;
        check("pre-arst x1_r", x1_r, 32'h80);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst x1_r", x1_r, 32'h0);
        check("arst rd_dat0", rd_dat[0 +: XL], 32'h0);
        check("arst busy_vec", 32'(busy_vec), 32'h0);
        check("arst iss_rdy", 32'(iss_rdy), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
